// File: rtl/tri_xor_acc_pkg.sv
// Shared definitions for the tri_xor_acc accumulator: FSM encoding and beat-count limits.
package tri_xor_acc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_t;

   localparam int                    BEAT_CNT_W   = 8;
   localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = 8'hFF;

   function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] cnt);
      return (cnt == BEAT_CNT_MAX) ? cnt : cnt + BEAT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/tri_xor_acc_tree.sv
// Masked NIN-way XOR of WIDTH-bit lanes; purely combinational.
module tri_xor_tree #(
   parameter int WIDTH = 64,
   parameter int NIN   = 4
) (
   input  logic [NIN*WIDTH-1:0] data,
   input  logic [NIN-1:0]       lane_en,
   output logic [WIDTH-1:0]     beat
);

   logic [WIDTH-1:0] masked [NIN];

   // Lane 0 sits in the most-significant slice and uses the most-significant enable bit.
   for (genvar gi = 0; gi < NIN; gi++) begin : g_lane
      assign masked[gi] = data[(NIN-1-gi)*WIDTH +: WIDTH] & {WIDTH{lane_en[NIN-1-gi]}};
   end

   for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
      logic [NIN-1:0] col;
      for (genvar gl = 0; gl < NIN; gl++) begin : g_col
         assign col[gl] = masked[gl][gb];
      end
      assign beat[gb] = ^col;
   end

endmodule

// File: rtl/tri_xor_acc.sv
// Pipelined multi-lane XOR accumulator: folds packets of beats into one result with parity,
// beat count and protocol-error flag, behind valid/ready handshakes on both sides.
module tri_xor_acc
   import tri_xor_acc_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NIN   = 4,
   parameter int PIPE  = 1
) (
   input  logic                  nclk,
   input  logic                  rst_n,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [NIN*WIDTH-1:0]  in_data,
   input  logic [NIN-1:0]        in_lane_en,
   input  logic                  in_first,
   input  logic                  in_last,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_parity,
   output logic [BEAT_CNT_W-1:0] out_beats,
   output logic                  out_err
);

   logic [WIDTH-1:0] beat_b;
   logic             rdy_en_reg;
   logic             out_can_load;
   logic             st_fire;
   logic [WIDTH-1:0] st_data;
   logic             st_first;
   logic             st_last;

   acc_state_t            state_reg, state_next;
   logic [WIDTH-1:0]      acc_reg, acc_next;
   logic [BEAT_CNT_W-1:0] cnt_reg, cnt_next;
   logic                  err_reg, err_next;
   logic                  out_vld_reg, out_vld_next;
   logic [WIDTH-1:0]      out_data_reg, out_data_next;
   logic                  out_parity_reg, out_parity_next;
   logic [BEAT_CNT_W-1:0] out_beats_reg, out_beats_next;
   logic                  out_err_reg, out_err_next;

   logic                  starting;
   logic [WIDTH-1:0]      beat_acc;
   logic [BEAT_CNT_W-1:0] beat_cnt;
   logic                  beat_err;

   tri_xor_tree #(.WIDTH(WIDTH), .NIN(NIN)) u_tree (
      .data    (in_data),
      .lane_en (in_lane_en),
      .beat    (beat_b)
   );

   assign out_can_load = !out_vld_reg | out_rdy;

   // Holds in_rdy low while in reset and for the first edge after release.
   always_ff @(posedge nclk or negedge rst_n) begin
      if (!rst_n) rdy_en_reg <= 1'b0;
      else        rdy_en_reg <= 1'b1;
   end

   if (PIPE != 0) begin : g_pipe
      logic             s1_vld_reg;
      logic             s1_first_reg;
      logic             s1_last_reg;
      logic [WIDTH-1:0] s1_data_reg;
      logic             s1_adv;

      // Only a last beat can block, and only while the output register is occupied.
      assign s1_adv = !s1_last_reg | out_can_load;
      assign in_rdy = rdy_en_reg & (!s1_vld_reg | s1_adv);

      always_ff @(posedge nclk or negedge rst_n) begin
         if (!rst_n) begin
            s1_vld_reg   <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_data_reg  <= '0;
         end else if (in_rdy) begin
            s1_vld_reg <= in_vld;
            if (in_vld) begin
               s1_first_reg <= in_first;
               s1_last_reg  <= in_last;
               s1_data_reg  <= beat_b;
            end
         end
      end

      assign st_fire  = s1_vld_reg & s1_adv;
      assign st_data  = s1_data_reg;
      assign st_first = s1_first_reg;
      assign st_last  = s1_last_reg;
   end else begin : g_bypass
      assign in_rdy   = rdy_en_reg & (out_can_load | !in_last);
      assign st_fire  = in_vld & in_rdy;
      assign st_data  = beat_b;
      assign st_first = in_first;
      assign st_last  = in_last;
   end

   always_comb begin
      state_next      = state_reg;
      acc_next        = acc_reg;
      cnt_next        = cnt_reg;
      err_next        = err_reg;
      out_vld_next    = out_vld_reg & !out_rdy;
      out_data_next   = out_data_reg;
      out_parity_next = out_parity_reg;
      out_beats_next  = out_beats_reg;
      out_err_next    = out_err_reg;

      // A first beat mid-packet, or any beat while idle, restarts the packet.
      starting = (state_reg == IDLE) | st_first;
      beat_acc = starting ? st_data : (acc_reg ^ st_data);
      beat_cnt = starting ? BEAT_CNT_W'(1) : sat_inc(cnt_reg);
      beat_err = (state_reg == IDLE) ? !st_first : (st_first | err_reg);

      if (st_fire) begin
         if (st_last) begin
            out_vld_next    = 1'b1;
            out_data_next   = beat_acc;
            out_parity_next = ^beat_acc;
            out_beats_next  = beat_cnt;
            out_err_next    = beat_err;
            state_next      = IDLE;
            acc_next        = '0;
            cnt_next        = '0;
            err_next        = 1'b0;
         end else begin
            state_next = ACCUM;
            acc_next   = beat_acc;
            cnt_next   = beat_cnt;
            err_next   = beat_err;
         end
      end
   end

   always_ff @(posedge nclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         acc_reg        <= '0;
         cnt_reg        <= '0;
         err_reg        <= 1'b0;
         out_vld_reg    <= 1'b0;
         out_data_reg   <= '0;
         out_parity_reg <= 1'b0;
         out_beats_reg  <= '0;
         out_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         acc_reg        <= acc_next;
         cnt_reg        <= cnt_next;
         err_reg        <= err_next;
         out_vld_reg    <= out_vld_next;
         out_data_reg   <= out_data_next;
         out_parity_reg <= out_parity_next;
         out_beats_reg  <= out_beats_next;
         out_err_reg    <= out_err_next;
      end
   end

   assign out_vld    = out_vld_reg;
   assign out_data   = out_data_reg;
   assign out_parity = out_parity_reg;
   assign out_beats  = out_beats_reg;
   assign out_err    = out_err_reg;

endmodule
